// File: rtl/sound_event_arbiter.sv
// rtl/sound_event_arbiter.sv - turns raw game event levels into fixed-length, mutually exclusive sound-play levels
module sound_event_arbiter #(
    parameter int JUMP_CYCLES = 2500000,
    parameter int WIN_CYCLES  = 25000000,
    parameter int LOSE_CYCLES = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic jump_fwd_in,
    input  logic jump_back_in,
    input  logic jump_right_in,
    input  logic jump_left_in,
    input  logic win_in,
    input  logic lose_in,
    output logic jump_fwd_out,
    output logic jump_back_out,
    output logic jump_right_out,
    output logic jump_left_out,
    output logic win_out,
    output logic lose_out,
    output logic busy
);

    localparam int MAX_JW = (JUMP_CYCLES > WIN_CYCLES) ? JUMP_CYCLES : WIN_CYCLES;
    localparam int MAX_C  = (MAX_JW > LOSE_CYCLES) ? MAX_JW : LOSE_CYCLES;
    localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] JUMP_LOAD = CW'(JUMP_CYCLES - 1);
    localparam logic [CW-1:0] WIN_LOAD  = CW'(WIN_CYCLES - 1);
    localparam logic [CW-1:0] LOSE_LOAD = CW'(LOSE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, JUMP, WIN, LOSE} state_t;

    localparam logic [1:0] DIR_FWD   = 2'd0;
    localparam logic [1:0] DIR_BACK  = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    state_t        state, next_state;
    logic [1:0]    dir, next_dir;
    logic [CW-1:0] cnt, next_cnt;
    logic [5:0]    in_vec, prev, edges;
    logic          expired, can_start;

    assign in_vec = {jump_fwd_in, jump_back_in, jump_right_in, jump_left_in, win_in, lose_in};
    assign edges  = in_vec & ~prev;

    // History resets to 1 so a level held across reset release is not an event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '1;
        end else begin
            prev <= in_vec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dir   <= DIR_FWD;
            cnt   <= '0;
        end else begin
            state <= next_state;
            dir   <= next_dir;
            cnt   <= next_cnt;
        end
    end

    // New sounds may start from IDLE, over a jump, or on any expiry cycle
    always_comb begin
        next_state = state;
        next_dir   = dir;
        next_cnt   = cnt;
        expired    = (cnt == '0);
        can_start  = (state == IDLE) || (state == JUMP) || expired;
        if (can_start && edges[1]) begin
            next_state = WIN;
            next_cnt   = WIN_LOAD;
        end else if (can_start && edges[0]) begin
            next_state = LOSE;
            next_cnt   = LOSE_LOAD;
        end else if (can_start && (edges[5:2] != 4'b0000)) begin
            next_state = JUMP;
            next_cnt   = JUMP_LOAD;
            if (edges[5])      next_dir = DIR_FWD;
            else if (edges[4]) next_dir = DIR_BACK;
            else if (edges[3]) next_dir = DIR_RIGHT;
            else               next_dir = DIR_LEFT;
        end else if (state != IDLE) begin
            if (expired) begin
                next_state = IDLE;
            end else begin
                next_cnt = cnt - CW'(1);
            end
        end
    end

    always_comb begin
        jump_fwd_out   = (state == JUMP) && (dir == DIR_FWD);
        jump_back_out  = (state == JUMP) && (dir == DIR_BACK);
        jump_right_out = (state == JUMP) && (dir == DIR_RIGHT);
        jump_left_out  = (state == JUMP) && (dir == DIR_LEFT);
        win_out        = (state == WIN);
        lose_out       = (state == LOSE);
        busy           = (state != IDLE);
    end

endmodule

// File: tb/tb_sound_event_arbiter.sv
// tb/tb_sound_event_arbiter.sv - directed and randomized self-checking bench for sound_event_arbiter
module tb_sound_event_arbiter;

    localparam int JC = 4;
    localparam int WC = 8;
    localparam int LC = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic jf_i = 1'b0, jb_i = 1'b0, jr_i = 1'b0, jl_i = 1'b0, win_i = 1'b0, lose_i = 1'b0;
    logic jf_o, jb_o, jr_o, jl_o, win_o, lose_o, busy_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference: active sound id (0 none, 1..4 jump fwd/back/right/left, 5 win, 6 lose) and cycles left
    int         snd = 0;
    int         rem = 0;
    logic [5:0] mprev = '1;

    sound_event_arbiter #(.JUMP_CYCLES(JC), .WIN_CYCLES(WC), .LOSE_CYCLES(LC)) dut (
        .clk(clk), .rst_n(rst_n),
        .jump_fwd_in(jf_i), .jump_back_in(jb_i), .jump_right_in(jr_i), .jump_left_in(jl_i),
        .win_in(win_i), .lose_in(lose_i),
        .jump_fwd_out(jf_o), .jump_back_out(jb_o), .jump_right_out(jr_o), .jump_left_out(jl_o),
        .win_out(win_o), .lose_out(lose_o), .busy(busy_o)
    );

    always #5 clk = ~clk;

    function automatic int sound_len(input int s);
        if (s == 5) return WC;
        if (s == 6) return LC;
        return JC;
    endfunction

    function automatic int pick(input logic [5:0] e);
        if (e[1]) return 5;
        if (e[0]) return 6;
        if (e[5]) return 1;
        if (e[4]) return 2;
        if (e[3]) return 3;
        if (e[2]) return 4;
        return 0;
    endfunction

    function automatic logic [6:0] expected_outs(input int s);
        logic [6:0] v;
        v = '0;
        if (s != 0) begin
            v[7 - s] = 1'b1;
            v[0]     = 1'b1;
        end
        return v;
    endfunction

    task automatic model_clock();
        logic [5:0] cur, e;
        int         nw;
        if (!rst_n) begin
            snd = 0; rem = 0; mprev = '1;
            return;
        end
        cur   = {jf_i, jb_i, jr_i, jl_i, win_i, lose_i};
        e     = cur & ~mprev;
        mprev = cur;
        nw    = pick(e);
        if (nw != 0 && (snd == 0 || snd <= 4 || rem == 1)) begin
            snd = nw;
            rem = sound_len(nw);
        end else if (snd != 0) begin
            rem--;
            if (rem == 0) snd = 0;
        end
    endtask

    task automatic check_outs(input string tag);
        logic [6:0] obs, exp_v;
        obs   = {jf_o, jb_o, jr_o, jl_o, win_o, lose_o, busy_o};
        exp_v = expected_outs(snd);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s cycle %0d: outs observed %b expected %b", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic step(input logic [5:0] v, input string tag);
        {jf_i, jb_i, jr_i, jl_i, win_i, lose_i} = v;
        @(posedge clk);
        cyc++;
        model_clock();
        #1;
        check_outs(tag);
    endtask

    task automatic steps(input logic [5:0] v, input int n, input string tag);
        for (int i = 0; i < n; i++) step(v, tag);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        snd = 0; rem = 0; mprev = '1;
        check_outs(tag);
    endtask

    initial begin
        // Reset held with jump_fwd and win high, then released: no event
        steps(6'b100010, 3, "reset_hold");
        rst_n = 1'b1;
        steps(6'b100010, 3, "held_through_release");
        step(6'b000010, "fwd_drop");
        step(6'b100010, "fwd_edge");
        tests++;
        assert (jf_o === 1'b1 && busy_o === 1'b1) else begin
            fails++;
            $error("FAIL fwd_first_cycle: jf=%b busy=%b expected 1 1", jf_o, busy_o);
        end
        steps(6'b100010, 5, "fwd_run");
        tests++;
        assert (busy_o === 1'b0) else begin
            fails++;
            $error("FAIL fwd_expired: busy=%b expected 0", busy_o);
        end

        // Long left level, then coincident back+right
        steps(6'b000000, 2, "idle");
        steps(6'b000100, 20, "left_held");
        steps(6'b000000, 2, "idle");
        step(6'b011000, "back_right_edge");
        steps(6'b000000, 5, "back_run");

        // Jump retrigger in another direction
        step(6'b100000, "fwd_edge2");
        step(6'b100000, "fwd_hold");
        step(6'b101000, "right_retrigger");
        steps(6'b000000, 6, "right_run");

        // Lose preempts jump; jump and win ignored during lose
        step(6'b100000, "fwd_edge3");
        step(6'b100001, "lose_preempt");
        step(6'b000001, "lose_run");
        step(6'b000011, "win_ignored");
        step(6'b100011, "jump_ignored");
        steps(6'b000000, 5, "lose_tail");

        // Coincident win+lose, then lose edge exactly on win expiry
        step(6'b000011, "win_lose_coincide");
        steps(6'b000000, 7, "win_run");
        step(6'b000001, "lose_on_expiry");
        tests++;
        assert (lose_o === 1'b1 && win_o === 1'b0) else begin
            fails++;
            $error("FAIL lose_no_gap: lose=%b win=%b expected 1 0", lose_o, win_o);
        end
        steps(6'b000000, 8, "lose_run2");

        // Reset mid-win, win still held after release
        step(6'b000010, "win_edge");
        steps(6'b000010, 2, "win_hold");
        async_reset("async_clear");
        step(6'b000010, "in_reset");
        rst_n = 1'b1;
        steps(6'b000010, 10, "after_reset");

        // Randomized traffic with sparse toggles and occasional reset pulses
        begin
            logic [5:0] v;
            v = '0;
            for (int i = 0; i < 3000; i++) begin
                for (int b = 0; b < 6; b++)
                    if ($urandom_range(0, 7) == 0) v[b] = ~v[b];
                if ($urandom_range(0, 499) == 0) begin
                    async_reset("rand_reset");
                    step(v, "rand_in_reset");
                    rst_n = 1'b1;
                end
                step(v, "random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sound_event_arbiter.md
Name: sound_event_arbiter

Overview:
- Sits directly upstream of the audio mixer. It turns raw game events (jump buttons, win, lose) into clean, fixed-length, mutually exclusive "play" levels.
- The mixer selects the jump, win or lose tone while the matching level is high.
- Raw inputs are levels of arbitrary length. Only rising edges start a sound.
- Win and lose sounds take priority over jump sounds.

Parameters:
JUMP_CYCLES, 2500000, clk cycles a jump level stays high (>=1)
WIN_CYCLES, 25000000, clk cycles win level stays high (>=1)
LOSE_CYCLES, 25000000, clk cycles lose level stays high (>=1)

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
jump_fwd_in  input  1  raw forward-jump request (level)
jump_back_in  input  1  raw backward-jump request (level)
jump_right_in  input  1  raw right-jump request (level)
jump_left_in  input  1  raw left-jump request (level)
win_in  input  1  raw game-won indication (level)
lose_in  input  1  raw game-lost indication (level)
jump_fwd_out  output  1  play jump sound, forward
jump_back_out  output  1  play jump sound, backward
jump_right_out  output  1  play jump sound, right
jump_left_out  output  1  play jump sound, left
win_out  output  1  play win sound
lose_out  output  1  play lose sound
busy  output  1  any output high

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n). While rst_n=0:
  - state=IDLE, counter=0, all outputs 0.
  - All six input-history registers are set to 1, so a level held through reset release produces no event.
- Edge detect per input: edge = in & ~prev; prev <= in every cycle.
- Edge timing: an edge is sampled at clock edge N when in was 0 at N-1 and 1 at N.
- Output timing: the resulting output is registered, goes high after edge N, and stays high for exactly its *_CYCLES cycles. There is no other latency.
- All outputs are registered. At most one output is high at any time. busy = OR of outputs.
- The counter is sized internally to hold the largest *_CYCLES value. It loads *_CYCLES-1 on entry and decrements to 0. Leaving happens on the clock edge where the counter equals 0.
- States: IDLE, JUMP (one direction register, 2 bits), WIN, LOSE.
- IDLE transitions:
  - Win edge -> WIN.
  - Else lose edge -> LOSE.
  - Else any jump edge -> JUMP.
- JUMP direction priority when several jump edges coincide: fwd > back > right > left.
- JUMP state:
  - Win or lose edge preempts: go to WIN or LOSE, jump output drops the same cycle the new output rises.
  - A new jump edge, in any direction (including the same one), retriggers: the counter reloads JUMP_CYCLES-1 and the direction updates. There is no gap cycle.
  - Counter expiry -> IDLE.
- WIN state:
  - All edges are ignored (no retrigger, no preemption by lose).
  - Expiry -> IDLE.
- LOSE state: same as WIN. It ignores all edges, including win.
- Events ignored while in WIN or LOSE are discarded, not queued.
- Coincident win and lose edges: win wins.
- Expiry cycle: an edge arriving on the expiry cycle is handled with IDLE priority. The new output begins immediately with no idle gap.
- Reset mid-operation: outputs clear asynchronously. After release, no sound restarts until a fresh rising edge.
- *_CYCLES=1 yields a single-cycle pulse.

Test Plan:
Bench parameters for all scenarios: JUMP_CYCLES=4, WIN_CYCLES=8, LOSE_CYCLES=6.
- Reset release with jump_fwd_in and win_in held at 1 -> all outputs stay 0. Dropping then re-raising jump_fwd_in -> jump_fwd_out high exactly 4 cycles, starting the cycle after the sampled edge; busy tracks it.
- jump_left_in held high 20 cycles -> jump_left_out high 4 cycles only. jump_back and jump_right edges on the same cycle -> only jump_back_out, 4 cycles.
- jump_fwd edge, then jump_right edge 2 cycles later -> jump_fwd_out high 2 cycles, then jump_right_out high 4 cycles, no gap, never both high.
- jump_fwd edge, then lose edge 1 cycle later -> jump_fwd_out high 1 cycle, lose_out high 6 cycles. A jump edge and a win edge during LOSE are both ignored; IDLE is reached after the 6 cycles.
- Coincident win and lose edges -> win_out high 8 cycles, lose_out stays 0. A lose edge exactly on the expiry cycle -> lose_out rises the next cycle with no gap and lasts 6 cycles.
- rst_n pulsed low mid-WIN (cycle 3 of 8) -> win_out drops asynchronously and stays 0 after release with win_in still 1.
